// File: rtl/adpll_lock_sequencer.sv
// adpll_lock_sequencer: ADPLL node controller that sequences warmup, schedules acquire/track gains, and flags lock and acquisition timeout.
module adpll_lock_sequencer #(
  parameter int PDET_WIDTH = 8,
  parameter int KP_WIDTH = 3,
  parameter int KI_WIDTH = 4,
  parameter logic [KP_WIDTH-1:0] KP_ACQ = 3'b100,
  parameter logic [KI_WIDTH-1:0] KI_ACQ = 4'b0100,
  parameter logic [KP_WIDTH-1:0] KP_TRK = 3'b010,
  parameter logic [KI_WIDTH-1:0] KI_TRK = 4'b0001,
  parameter int WARMUP_CYCLES = 256,
  parameter int LOCK_THRESH = 4,
  parameter int UNLOCK_THRESH = 16,
  parameter int ACQ_GOOD = 8,
  parameter int LOCK_GOOD = 16,
  parameter int UNLOCK_BAD = 4,
  parameter int TIMEOUT_SAMPLES = 1024
) (
  input  logic                  fpga_clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  sample_i,
  input  logic [PDET_WIDTH-1:0] error_i,
  output logic                  osc_enable_o,
  output logic                  loop_reset_o,
  output logic [KP_WIDTH-1:0]   kp_o,
  output logic [KI_WIDTH-1:0]   ki_o,
  output logic                  locked_o,
  output logic                  timeout_o,
  output logic [2:0]            state_o
);
  typedef enum logic [2:0] {IDLE = 3'd0, WARMUP = 3'd1, ACQUIRE = 3'd2, TRACK = 3'd3, LOCKED = 3'd4} state_t;
  localparam int GW = $clog2((ACQ_GOOD > LOCK_GOOD ? ACQ_GOOD : LOCK_GOOD) + 1);
  localparam int BW = $clog2(UNLOCK_BAD + 1);
  localparam logic [PDET_WIDTH-1:0] MOST_NEG = {1'b1, {(PDET_WIDTH-1){1'b0}}};
  localparam logic [PDET_WIDTH-1:0] LOCK_T = PDET_WIDTH'(LOCK_THRESH);
  localparam logic [PDET_WIDTH-1:0] UNLOCK_T = PDET_WIDTH'(UNLOCK_THRESH);
  localparam logic [15:0] WARM_LAST = 16'(WARMUP_CYCLES - 1);
  localparam logic [GW-1:0] ACQ_LAST = GW'(ACQ_GOOD - 1);
  localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_GOOD - 1);
  localparam logic [BW-1:0] BAD_LAST = BW'(UNLOCK_BAD - 1);
  localparam logic [11:0] TO_LAST = 12'(TIMEOUT_SAMPLES - 1);
  state_t state, nxt;
  logic [15:0] warm_cnt, warm_nxt, warm_inc;
  logic [GW-1:0] good_cnt, good_nxt, good_inc;
  logic [BW-1:0] bad_cnt, bad_nxt, bad_inc;
  logic [11:0] samp_cnt, samp_nxt, samp_inc;
  logic [PDET_WIDTH-1:0] abs_err;
  logic good, bad, to_nxt, trk;
  assign abs_err = !error_i[PDET_WIDTH-1] ? error_i : error_i == MOST_NEG ? ~MOST_NEG : -error_i;
  assign good = sample_i && abs_err <= LOCK_T;
  assign bad = sample_i && abs_err > UNLOCK_T;
  assign warm_inc = &warm_cnt ? warm_cnt : warm_cnt + 16'd1;
  assign good_inc = &good_cnt ? good_cnt : good_cnt + GW'(1);
  assign bad_inc = &bad_cnt ? bad_cnt : bad_cnt + BW'(1);
  assign samp_inc = &samp_cnt ? samp_cnt : samp_cnt + 12'd1;
  assign trk = nxt == TRACK || nxt == LOCKED;
  assign state_o = state;
  always_comb begin
    nxt = state;
    warm_nxt = '0;
    good_nxt = good_cnt;
    bad_nxt = bad_cnt;
    samp_nxt = samp_cnt;
    to_nxt = timeout_o;
    case (state)
      IDLE: begin
        good_nxt = '0;
        bad_nxt = '0;
        samp_nxt = '0;
        to_nxt = 1'b0;
        nxt = start_i ? WARMUP : IDLE;
      end
      WARMUP: begin
        good_nxt = '0;
        bad_nxt = '0;
        samp_nxt = '0;
        warm_nxt = warm_inc;
        nxt = warm_cnt == WARM_LAST ? ACQUIRE : WARMUP;
      end
      ACQUIRE, TRACK: begin
        samp_nxt = sample_i ? samp_inc : samp_cnt;
        good_nxt = good ? good_inc : sample_i ? '0 : good_cnt;
        if (state == ACQUIRE && good && good_cnt == ACQ_LAST) begin
          nxt = TRACK;
          good_nxt = '0;
        end
        if (state == TRACK && good && good_cnt == LOCK_LAST) begin
          nxt = LOCKED;
          good_nxt = '0;
        end
        if (state == TRACK && bad) begin
          nxt = ACQUIRE;
          good_nxt = '0;
        end
        if (sample_i && samp_cnt == TO_LAST) begin
          nxt = WARMUP;
          to_nxt = 1'b1;
          good_nxt = '0;
        end
      end
      LOCKED: begin
        bad_nxt = bad ? bad_inc : sample_i ? '0 : bad_cnt;
        if (bad && bad_cnt == BAD_LAST) begin
          nxt = ACQUIRE;
          good_nxt = '0;
          bad_nxt = '0;
          samp_nxt = '0;
        end
      end
      default: nxt = IDLE;
    endcase
    if (!start_i) begin
      nxt = IDLE;
      to_nxt = 1'b0;
      good_nxt = '0;
      bad_nxt = '0;
      samp_nxt = '0;
    end
  end
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      warm_cnt <= '0;
      good_cnt <= '0;
      bad_cnt <= '0;
      samp_cnt <= '0;
      osc_enable_o <= 1'b0;
      loop_reset_o <= 1'b1;
      kp_o <= KP_ACQ;
      ki_o <= KI_ACQ;
      locked_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state <= nxt;
      warm_cnt <= warm_nxt;
      good_cnt <= good_nxt;
      bad_cnt <= bad_nxt;
      samp_cnt <= samp_nxt;
      osc_enable_o <= nxt != IDLE;
      loop_reset_o <= nxt == IDLE || nxt == WARMUP;
      kp_o <= trk ? KP_TRK : KP_ACQ;
      ki_o <= trk ? KI_TRK : KI_ACQ;
      locked_o <= nxt == LOCKED;
      timeout_o <= to_nxt;
    end
  end
endmodule
